// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI responder clocked by clk; SCLK/SS/MOSI are oversampled, modes 0-3, MSB first.
// Optional build macro SPI_SLAVE_STATUS_EN adds rx_ack/status_clr inputs and sticky overrun/underrun flags.

module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              SCLK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic              rx_ack,
    input  logic              status_clr,
    output logic              overrun,
    output logic              underrun
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic [1:0]             mode_q;
    logic                   cpol, cpha;

    logic [DATA_W-1:0]      hold;
    logic                   hold_full;
    logic [DATA_W-1:0]      next_word;
    logic [DATA_W-1:0]      tx_sr;
    logic [DATA_W-2:0]      rx_sr;
    logic [DATA_W-1:0]      rx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload_pend;
    logic                   word_end, reload, load_any;

    // SS chain resets low so a frame already in flight at reset release never looks like a fresh SS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    assign cpol        = mode_q[1];
    assign cpha        = mode_q[0];
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    assign next_word = hold_full ? hold : '0;
    assign rx_shift  = {rx_sr, mosi_s};
    assign tx_ready  = ~hold_full;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        word_end = 1'b0;
        reload   = 1'b0;
        load_any = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_nx = LOAD;
            LOAD: begin
                load_any = 1'b1;
                state_nx = ss_rise ? IDLE : XFER;
            end
            XFER: begin
                word_end = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));
                reload   = shift_edge && reload_pend && !ss_rise;
                load_any = reload;
                if (ss_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // tx_valid/tx_ready: a word is taken on any clk where both are high; tx_data must hold while tx_valid waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (load_any) hold_full <= 1'b0;
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 2'b00;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) mode_q <= mode;
                end
                LOAD: begin
                    tx_sr       <= next_word;
                    bit_cnt     <= '0;
                    reload_pend <= 1'b0;
                    MISO        <= (cpha || ss_rise) ? 1'b0 : next_word[DATA_W-1];
                end
                XFER: begin
                    if (sample_edge) begin
                        rx_sr <= rx_shift[DATA_W-2:0];
                        if (word_end) begin
                            rx_data     <= rx_shift;
                            rx_valid    <= 1'b1;
                            bit_cnt     <= '0;
                            reload_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    // A reload starts the next word: CPHA=1 drives its MSB now, so the register keeps the rest.
                    if (reload) begin
                        reload_pend <= 1'b0;
                        MISO        <= next_word[DATA_W-1];
                        tx_sr       <= cpha ? {next_word[DATA_W-2:0], 1'b0} : next_word;
                    end else if (shift_edge && !ss_rise) begin
                        MISO  <= cpha ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                    if (ss_rise) begin
                        MISO        <= 1'b0;
                        reload_pend <= 1'b0;
                    end
                end
                default: MISO <= 1'b0;
            endcase
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic rx_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_pend  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (rx_ack)   rx_pend <= 1'b0;
            if (word_end) rx_pend <= 1'b1;
            if (status_clr) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end
            if (word_end && rx_pend && !rx_ack) overrun <= 1'b1;
            if (load_any && !hold_full)         underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- System-clocked SPI responder; the counterpart to the team's `master` initiator.
- Runs entirely on `clk`. SCLK, SS and MOSI are oversampled through synchronizers rather than used as clocks.
- Supports SPI modes 0-3, MSB first, fixed DATA_W-bit words, back-to-back words while SS stays low.
- Presents a valid/ready TX holding register and a one-cycle RX pulse to on-chip logic; sits between the SPI pins and the device register file.

Parameters:
- DATA_W, 8: word length in bits; must be >= 2.
- SYNC_STAGES, 2: synchronizer flop depth on SCLK/SS/MOSI; must be >= 2.

Ports:
- clk  input  1  system clock; SCLK frequency <= clk/(2*(SYNC_STAGES+2)).
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  {CPOL,CPHA}; captured at SS falling edge.
- SCLK  input  1  SPI serial clock from master.
- SS  input  1  active-low slave select.
- MOSI  input  1  master-out serial data.
- MISO  output  1  slave-out serial data.
- tx_data  input  DATA_W  next word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  TX holding register is empty.
- rx_data  output  DATA_W  last fully received word.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  frame in progress (synchronized SS low).

Behaviour:
- Reset values (asynchronous, active-high): MISO=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, FSM=IDLE, bit count=0, holding register empty.
- Synchronizers:
  - SCLK, SS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized SCLK/SS with one extra flop.
  - Detection latency is exactly SYNC_STAGES+1 clk from the pin transition.
- Mode decode:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1; the shift edge is the other one.
  - `mode` is latched at the SS falling edge; changes mid-frame are ignored.
- TX holding register (depth 1):
  - tx_valid && tx_ready writes tx_data and sets tx_ready=0.
  - It is consumed when a word is loaded into the shift register, which sets tx_ready=1 on the next clk.
  - If empty at load time (underrun), the shift register loads all zeros.
- FSM IDLE -> LOAD -> XFER -> IDLE:
  - IDLE: MISO=0, busy=0. On SS fall go to LOAD.
  - LOAD (1 cycle): latch mode, load the shift register from the holding register, clear bit count. For CPHA=0, drive MISO = word MSB. busy=1. Go to XFER.
  - XFER on sample edge: shift synchronized MOSI into the RX shift register LSB and increment bit count.
  - XFER on shift edge:
    - CPHA=0: shift the TX register left, MISO = new MSB.
    - CPHA=1: MISO = current MSB, then shift.
    - The shift edge that immediately follows the LOAD for CPHA=0 is not ignored (it is the trailing edge of bit 0 and advances to bit 1).
  - Word completion: when bit count reaches DATA_W on a sample edge, rx_data <= RX shift register contents, rx_valid=1 for exactly one clk, bit count <= 0.
  - Back-to-back: after a completed word with SS still low, the next shift edge reloads the TX shift register from the holding register (underrun -> zeros) and drives its MSB. There is no gap cycle between words.
  - SS rise in XFER: abort immediately, discard the partial RX word (no rx_valid), MISO=0, go to IDLE. The holding register is untouched if it was not yet consumed.
- Simultaneous events:
  - SS rise on the same clk as the final sample edge: the word completes and rx_valid pulses, then IDLE.
  - tx_valid write on the same clk as a load: the load takes the old contents; the new write is accepted only if tx_ready was 1 on that cycle.
- rst asserted mid-frame: all state returns to reset values immediately. The remainder of the frame is ignored until SS is seen high and then low again.

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- When defined, two outputs are added:
  - overrun (1 bit): set when a word completes while the previous rx_valid word is unacknowledged. Acknowledgement uses an added rx_ack input.
  - underrun (1 bit): set when a load occurs with the holding register empty.
  - Both flags are sticky and cleared by an added input status_clr (1 bit). Both reset to 0.
- When not defined: no extra ports, no rx_ack; rx_data is simply overwritten and underrun is silent.

Test Plan:
- Mode 0, DATA_W=8, tx_data=0xA5 preloaded, master sends 0x3C: MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready returns to 1 after the load.
- Modes 1, 2, 3 each: master sends 0xC3, tx_data=0x5A; rx_data=0xC3 and the master receives 0x5A in every mode.
- Back-to-back, mode 3: SS held low for 16 SCLKs, TX words 0x11 then 0x22 (0x22 written during word 1), master sends 0xF0, 0x0F. Expect two rx_valid pulses (0xF0, 0x0F) and MISO carrying 0x11 then 0x22 with no gap.
- Abort: SS raised after 5 SCLKs of word 0x99: no rx_valid, busy=0, MISO=0. The next full frame receives correctly.
- Underrun: no tx_valid, frame of 0x77: MISO all 0, rx_data=0x77. With SPI_SLAVE_STATUS_EN, underrun=1 until status_clr.
- rst asserted mid-frame after 3 bits: all outputs at reset values. The following SS-low frame 0xE1 is received correctly.
